// File: rtl/pipe_adder_chunk.sv
// Combinational CHUNK-bit ripple-carry adder built from full-adder cells.
// Also exposes the carry into its top bit so the caller can derive signed overflow.
module pipe_adder_chunk #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co,
  output logic         c_msb_in
);

  logic [W:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co       = c[W];
  assign c_msb_in = c[W-1];

endmodule

// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit add/subtract: one CHUNK-bit slice per stage with the carry
// registered between stages, operands skewed forward, and a global stall.
module pipe_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int CHUNK = WIDTH / STAGES;

  logic stall;

  if ((WIDTH % STAGES) != 0 || STAGES < 1 || STAGES > WIDTH) begin : g_bad_params
    $error("pipe_adder: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] s_next;
    logic             cin;
    logic             vld_in;
    logic [CHUNK-1:0] chunk_s;
    logic             chunk_co;
    logic             chunk_msb;
    logic [WIDTH-1:0] s_r;
    logic             c_r;
    logic             vld_r;

    // Stage input: raw operands for the first slice, previous stage register otherwise
    if (k == 0) begin : g_in
      assign op_a   = a;
      assign op_b   = sub ? ~b : b;
      assign cin    = sub | c_in;
      assign acc    = '0;
      assign vld_in = in_valid & in_ready;
    end else begin : g_link
      assign op_a   = g_stage[k-1].g_skew.a_r;
      assign op_b   = g_stage[k-1].g_skew.b_r;
      assign cin    = g_stage[k-1].c_r;
      assign acc    = g_stage[k-1].s_r;
      assign vld_in = g_stage[k-1].vld_r;
    end

    pipe_adder_chunk #(.W(CHUNK)) u_chunk (
      .a        (op_a[k*CHUNK +: CHUNK]),
      .b        (op_b[k*CHUNK +: CHUNK]),
      .ci       (cin),
      .s        (chunk_s),
      .co       (chunk_co),
      .c_msb_in (chunk_msb)
    );

    always_comb begin
      s_next = acc;
      s_next[k*CHUNK +: CHUNK] = chunk_s;
    end

    // Stage register: valid and partial sum; only the final stage's data is cleared
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_r <= 1'b0;
        if (k == STAGES - 1) begin
          s_r <= '0;
          c_r <= 1'b0;
        end
      end else if (!stall) begin
        vld_r <= vld_in;
        s_r   <= s_next;
        c_r   <= chunk_co;
      end
    end

    if (k < STAGES - 1) begin : g_skew
      logic [WIDTH-1:0] a_r;
      logic [WIDTH-1:0] b_r;
      logic             unused_msb;

      assign unused_msb = chunk_msb;

      always_ff @(posedge clk) begin
        if (!stall) begin
          a_r <= op_a;
          b_r <= op_b;
        end
      end
    end else begin : g_last
      logic ovf_r;
      logic unused_ops;

      assign unused_ops = ^{op_a, op_b};

      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_r <= 1'b0;
        end else if (!stall) begin
          ovf_r <= chunk_co ^ chunk_msb;
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].vld_r;
  assign sum       = g_stage[STAGES-1].s_r;
  assign c_out     = g_stage[STAGES-1].c_r;
  assign ovf       = g_stage[STAGES-1].g_last.ovf_r;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~rst & ~stall;

endmodule

// File: tb/tb_pipe_adder.sv
// Bench for pipe_adder (WIDTH=16, STAGES=4): directed corner cases plus random beats
// scored against an arithmetic reference model, with backpressure and mid-flight reset.
module tb_pipe_adder;
  localparam int WIDTH  = 16;
  localparam int STAGES = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;

  int checks   = 0;
  int failures = 0;

  // Expected results in acceptance order, packed as {ovf, c_out, sum}
  logic [WIDTH+1:0] exp_q[$];

  always #5 clk = ~clk;

  pipe_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .ovf       (ovf)
  );

  function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                             input logic ci, input logic s);
    logic [WIDTH-1:0] yy;
    logic [WIDTH:0]   t;
    logic             v;
    yy = s ? ~y : y;
    t  = {1'b0, x} + {1'b0, yy} + {{WIDTH{1'b0}}, (s | ci)};
    v  = (x[WIDTH-1] == yy[WIDTH-1]) && (t[WIDTH-1] != x[WIDTH-1]);
    return {v, t};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                       input logic ci, input logic s);
    in_valid = 1'b1;
    a        = x;
    b        = y;
    c_in     = ci;
    sub      = s;
  endtask

  task automatic directed(input string tag, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                          input logic ci, input logic s, input logic [WIDTH+1:0] want);
    drive(x, y, ci, s);
    for (int i = 0; i <= STAGES; i++) begin
      @(negedge clk);
      check({tag, "_valid"}, out_valid, (i == STAGES));
      if (i == STAGES) check({tag, "_value"}, {ovf, c_out, sum}, want);
      next_cycle();
      in_valid = 1'b0;
    end
  endtask

  // Scoreboard: record accepted beats, compare delivered results in order
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("out_without_beat", out_valid, 1'b0);
        end else begin
          check("result", {ovf, c_out, sum}, exp_q[0]);
          void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, c_in, sub));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH+1:0] held;
    logic [WIDTH-1:0] rx;
    logic [WIDTH-1:0] ry;
    logic             rc;
    logic             rs;

    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    c_in      = 1'b0;
    sub       = 1'b0;
    out_ready = 1'b1;

    repeat (2) next_cycle();
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_sum", sum, 16'h0000);
    check("rst_c_out", c_out, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", in_ready, 1'b1);
    next_cycle();

    directed("add_ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 16'h8000});
    directed("ripple",     16'hFFFF, 16'h0000, 1'b1, 1'b0, {1'b0, 1'b1, 16'h0000});
    directed("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, {1'b0, 1'b0, 16'hFFFE});
    directed("sub_ovf",    16'h8000, 16'h0001, 1'b0, 1'b1, {1'b1, 1'b1, 16'h7FFF});

    // Back-to-back random beats with the consumer always ready
    for (int i = 0; i < 13; i++) begin
      if (i < 8) drive(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      else in_valid = 1'b0;
      @(negedge clk);
      check("tput_valid", out_valid, (i >= STAGES && i < STAGES + 8));
      next_cycle();
    end
    check("tput_drained", exp_q.size(), 0);

    // Backpressure: four beats in flight, consumer stalls for three cycles
    for (int i = 0; i < 4; i++) begin
      drive(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      next_cycle();
    end
    held      = exp_q[0];
    out_ready = 1'b0;
    drive(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_hold", {ovf, c_out, sum}, held);
      next_cycle();
    end
    out_ready = 1'b1;
    next_cycle();
    in_valid = 1'b0;
    for (int i = 0; i < 4 * STAGES && exp_q.size() != 0; i++) next_cycle();
    check("bp_drained", exp_q.size(), 0);

    // Reset with three beats in flight
    for (int i = 0; i < 3; i++) begin
      drive(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      next_cycle();
    end
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready", in_ready, 1'b0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_out_valid", out_valid, 1'b0);
    check("post_rst_sum", sum, 16'h0000);
    check("post_rst_c_out", c_out, 1'b0);
    check("post_rst_ovf", ovf, 1'b0);
    next_cycle();
    for (int i = 0; i < 2 * STAGES; i++) begin
      @(negedge clk);
      check("post_rst_no_stale", out_valid, 1'b0);
      next_cycle();
    end
    rx = 16'($urandom);
    ry = 16'($urandom);
    rc = 1'($urandom);
    rs = 1'($urandom);
    directed("post_rst_beat", rx, ry, rc, rs, model(rx, ry, rc, rs));

    check("final_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
